regfile_mp: RTL and testbench

//  Parametrised multi-port integer register file for the RV32I/RV32E core family.

---
 rtl/regfile_pkg.sv | 17 +
 rtl/regfile_scoreboard.sv | 55 +++++
 rtl/regfile_mp.sv | 123 ++++++++++++
 tb/tb_regfile_mp.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared types and constants for the multi-port integer register file.
package regfile_pkg;

  typedef enum logic {
    RF_CLEAR = 1'b0,
    RF_RUN   = 1'b1
  } rf_state_e;

  localparam int RV32I_DEPTH = 32;
  localparam int RV32E_DEPTH = 16;

  // True when two register addresses match and name a real register (not x0).
  function automatic logic hits(input logic [31:0] a, input logic [31:0] b);
    return (a == b) && (a != 32'd0);
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register pending bits: set by decode allocations, cleared by committed writes.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int DEPTH     = RV32I_DEPTH,
  parameter int NUM_READ  = 2,
  parameter int NUM_WRITE = 1,
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [NUM_WRITE-1:0]    write_enable,
  input  logic [NUM_WRITE*AW-1:0] write_reg,
  input  logic                    alloc_enable,
  input  logic [AW-1:0]           alloc_reg,
  input  logic [NUM_READ*AW-1:0]  read_reg,
  output logic [NUM_READ-1:0]     read_pending
);

  logic [DEPTH-1:0] pend_q, pend_d;

  // A same-edge alloc outranks the clear: the alloc names a newer producer.
  always_comb begin
    logic clr;
    logic set;
    pend_d = pend_q;
    clr    = 1'b0;
    set    = 1'b0;
    for (int r = 0; r < DEPTH; r++) begin
      clr = 1'b0;
      for (int j = 0; j < NUM_WRITE; j++) begin
        clr = clr | (write_enable[j] & hits(32'(write_reg[j*AW +: AW]), 32'(r)));
      end
      set       = alloc_enable & hits(32'(alloc_reg), 32'(r));
      pend_d[r] = enable ? (set | (pend_q[r] & ~clr)) : pend_q[r];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pend_q <= '0;
    end else begin
      pend_q <= pend_d;
    end
  end

  always_comb begin
    read_pending = '0;
    for (int i = 0; i < NUM_READ; i++) begin
      read_pending[i] = pend_q[read_reg[i*AW +: AW]];
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file with sequential clear after reset,
// optional write-to-read bypass and a pending scoreboard for the pipeline.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int DEPTH     = RV32I_DEPTH,
  parameter int NUM_READ  = 2,
  parameter int NUM_WRITE = 1,
  parameter int BYPASS    = 1,
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NUM_READ*AW-1:0]    read_reg,
  output logic [NUM_READ*XLEN-1:0]  read_data,
  output logic [NUM_READ-1:0]       read_pending,
  input  logic [NUM_WRITE-1:0]      write_enable,
  input  logic [NUM_WRITE*AW-1:0]   write_reg,
  input  logic [NUM_WRITE*XLEN-1:0] write_data,
  input  logic                      alloc_enable,
  input  logic [AW-1:0]             alloc_reg,
  output logic                      ready
);

  rf_state_e       state_q, state_d;
  logic [AW-1:0]   clear_idx_q, clear_idx_d;
  logic            ready_q, ready_d;
  logic [XLEN-1:0] mem_q [DEPTH];
  logic [XLEN-1:0] mem_d [DEPTH];
  logic [NUM_READ-1:0] sb_pending;

  // Clear one entry per edge, then commit writes; ascending port order lets the highest port win.
  always_comb begin
    state_d     = state_q;
    clear_idx_d = clear_idx_q;
    mem_d       = mem_q;
    case (state_q)
      RF_CLEAR: begin
        mem_d[clear_idx_q] = {XLEN{1'b0}};
        clear_idx_d        = clear_idx_q + AW'(1);
        if (clear_idx_q == AW'(DEPTH - 1)) begin
          state_d = RF_RUN;
        end else begin
          state_d = RF_CLEAR;
        end
      end
      RF_RUN: begin
        for (int j = 0; j < NUM_WRITE; j++) begin
          mem_d[write_reg[j*AW +: AW]] =
            (write_enable[j] && (write_reg[j*AW +: AW] != {AW{1'b0}}))
              ? write_data[j*XLEN +: XLEN] : mem_d[write_reg[j*AW +: AW]];
        end
      end
      default: begin
        state_d = RF_CLEAR;
      end
    endcase
    ready_d = (state_d == RF_RUN);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= RF_CLEAR;
      clear_idx_q <= {AW{1'b0}};
      ready_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      clear_idx_q <= clear_idx_d;
      ready_q     <= ready_d;
    end
  end

  // Storage has no reset of its own; the clear sequence zeroes it.
  always_ff @(posedge clock) begin
    if (!reset) begin
      mem_q <= mem_d;
    end
  end

  regfile_scoreboard #(
    .DEPTH     (DEPTH),
    .NUM_READ  (NUM_READ),
    .NUM_WRITE (NUM_WRITE)
  ) u_scoreboard (
    .clock        (clock),
    .reset        (reset),
    .enable       (ready_q),
    .write_enable (write_enable),
    .write_reg    (write_reg),
    .alloc_enable (alloc_enable),
    .alloc_reg    (alloc_reg),
    .read_reg     (read_reg),
    .read_pending (sb_pending)
  );

  always_comb begin
    logic [AW-1:0] ra;
    logic          byp;
    read_data    = '0;
    read_pending = '0;
    ra           = {AW{1'b0}};
    byp          = 1'b0;
    for (int i = 0; i < NUM_READ; i++) begin
      ra = read_reg[i*AW +: AW];
      if (ready_q && (ra != {AW{1'b0}})) begin
        read_data[i*XLEN +: XLEN] = mem_q[ra];
        read_pending[i]           = sb_pending[i];
        for (int j = 0; j < NUM_WRITE; j++) begin
          byp = (BYPASS != 0) && write_enable[j] && hits(32'(write_reg[j*AW +: AW]), 32'(ra));
          read_data[i*XLEN +: XLEN] = byp ? write_data[j*XLEN +: XLEN] : read_data[i*XLEN +: XLEN];
          read_pending[i]           = read_pending[i] & ~byp;
        end
      end else begin
        read_data[i*XLEN +: XLEN] = {XLEN{1'b0}};
        read_pending[i]           = 1'b0;
      end
    end
  end

  assign ready = ready_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Randomized bench for regfile_mp: a 32-entry bypassing instance and a 16-entry
// non-bypassing, four-read instance, both checked against an array-based reference.
module tb_regfile_mp;
  localparam int XLEN = 32;
  localparam int NR_A = 2;
  localparam int NR_B = 4;
  localparam int NW   = 2;
  localparam int AW_A = 5;
  localparam int AW_B = 4;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic [NR_A*AW_A-1:0] rr_a;
  logic [NR_A*XLEN-1:0] rd_a;
  logic [NR_A-1:0]      rp_a;
  logic [NW-1:0]        we_a;
  logic [NW*AW_A-1:0]   wr_a;
  logic [NW*XLEN-1:0]   wd_a;
  logic                 ae_a;
  logic [AW_A-1:0]      ar_a;
  logic                 rdy_a;

  logic [NR_B*AW_B-1:0] rr_b;
  logic [NR_B*XLEN-1:0] rd_b;
  logic [NR_B-1:0]      rp_b;
  logic [NW-1:0]        we_b;
  logic [NW*AW_B-1:0]   wr_b;
  logic [NW*XLEN-1:0]   wd_b;
  logic                 ae_b;
  logic [AW_B-1:0]      ar_b;
  logic                 rdy_b;

  // Per-instance stimulus; index 0 is instance A, 1 is instance B.
  int          depth  [2] = '{32, 16};
  int          nr     [2] = '{NR_A, NR_B};
  int          bypass [2] = '{1, 0};
  logic [4:0]  s_raddr [2][4];
  logic        s_we    [2][NW];
  logic [4:0]  s_waddr [2][NW];
  logic [31:0] s_wdata [2][NW];
  logic        s_ae    [2];
  logic [4:0]  s_aaddr [2];

  // Reference model state.
  logic [31:0] m_mem  [2][32];
  logic        m_pend [2][32];
  int          m_cnt  [2];

  int n_checks = 0;
  int n_errors = 0;
  bit check_en = 1'b0;

  regfile_mp #(.XLEN(XLEN), .DEPTH(32), .NUM_READ(NR_A), .NUM_WRITE(NW), .BYPASS(1)) dut_a (
    .clock(clock), .reset(reset), .read_reg(rr_a), .read_data(rd_a), .read_pending(rp_a),
    .write_enable(we_a), .write_reg(wr_a), .write_data(wd_a),
    .alloc_enable(ae_a), .alloc_reg(ar_a), .ready(rdy_a));

  regfile_mp #(.XLEN(XLEN), .DEPTH(16), .NUM_READ(NR_B), .NUM_WRITE(NW), .BYPASS(0)) dut_b (
    .clock(clock), .reset(reset), .read_reg(rr_b), .read_data(rd_b), .read_pending(rp_b),
    .write_enable(we_b), .write_reg(wr_b), .write_data(wd_b),
    .alloc_enable(ae_b), .alloc_reg(ar_b), .ready(rdy_b));

  always_comb begin
    rr_a = '0; rr_b = '0; we_a = '0; wr_a = '0; wd_a = '0; we_b = '0; wr_b = '0; wd_b = '0;
    for (int i = 0; i < NR_A; i++) rr_a[i*AW_A +: AW_A] = s_raddr[0][i];
    for (int i = 0; i < NR_B; i++) rr_b[i*AW_B +: AW_B] = s_raddr[1][i][AW_B-1:0];
    for (int j = 0; j < NW; j++) begin
      we_a[j] = s_we[0][j];
      wr_a[j*AW_A +: AW_A] = s_waddr[0][j];
      wd_a[j*XLEN +: XLEN] = s_wdata[0][j];
      we_b[j] = s_we[1][j];
      wr_b[j*AW_B +: AW_B] = s_waddr[1][j][AW_B-1:0];
      wd_b[j*XLEN +: XLEN] = s_wdata[1][j];
    end
    ae_a = s_ae[0];
    ar_a = s_aaddr[0];
    ae_b = s_ae[1];
    ar_b = s_aaddr[1][AW_B-1:0];
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %h required %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] obs_data(input int k, input int i);
    return (k == 0) ? rd_a[i*XLEN +: XLEN] : rd_b[i*XLEN +: XLEN];
  endfunction

  function automatic logic obs_pend(input int k, input int i);
    return (k == 0) ? rp_a[i] : rp_b[i];
  endfunction

  task automatic idle();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 4; i++) s_raddr[k][i] = 5'd0;
      for (int j = 0; j < NW; j++) begin
        s_we[k][j] = 1'b0;
        s_waddr[k][j] = 5'd0;
        s_wdata[k][j] = 32'd0;
      end
      s_ae[k] = 1'b0;
      s_aaddr[k] = 5'd0;
    end
  endtask

  // Expected combinational outputs from the model state and the current inputs.
  task automatic check_outputs();
    logic [31:0] exp_d;
    logic        exp_p;
    logic [4:0]  a;
    for (int k = 0; k < 2; k++) begin
      check_eq($sformatf("k%0d_ready", k), 32'((k == 0) ? rdy_a : rdy_b), 32'(m_cnt[k] >= depth[k]));
      for (int i = 0; i < nr[k]; i++) begin
        a = s_raddr[k][i];
        exp_d = 32'd0;
        exp_p = 1'b0;
        if (m_cnt[k] >= depth[k] && a != 5'd0) begin
          exp_d = m_mem[k][a];
          exp_p = m_pend[k][a];
          if (bypass[k] != 0) begin
            for (int j = 0; j < NW; j++) begin
              if (s_we[k][j] && s_waddr[k][j] == a) begin
                exp_d = s_wdata[k][j];
                exp_p = 1'b0;
              end
            end
          end
        end
        check_eq($sformatf("k%0d_rdata%0d", k, i), obs_data(k, i), exp_d);
        check_eq($sformatf("k%0d_rpend%0d", k, i), 32'(obs_pend(k, i)), 32'(exp_p));
      end
    end
  endtask

  // Model update for one rising edge.
  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        m_cnt[k] = 0;
        for (int r = 0; r < 32; r++) m_pend[k][r] = 1'b0;
      end else if (m_cnt[k] < depth[k]) begin
        m_cnt[k]++;
        if (m_cnt[k] == depth[k]) begin
          for (int r = 0; r < 32; r++) m_mem[k][r] = 32'd0;
        end
      end else begin
        for (int j = 0; j < NW; j++) begin
          if (s_we[k][j] && s_waddr[k][j] != 5'd0) begin
            m_mem[k][s_waddr[k][j]] = s_wdata[k][j];
            m_pend[k][s_waddr[k][j]] = 1'b0;
          end
        end
        if (s_ae[k] && s_aaddr[k] != 5'd0) m_pend[k][s_aaddr[k]] = 1'b1;
      end
    end
  endtask

  task automatic run_cycle();
    #1;
    if (check_en) check_outputs();
    @(posedge clock);
    model_step();
    @(negedge clock);
  endtask

  task automatic write_both(input int port, input logic [4:0] addr, input logic [31:0] data);
    for (int k = 0; k < 2; k++) begin
      s_we[k][port] = 1'b1;
      s_waddr[k][port] = addr;
      s_wdata[k][port] = data;
    end
  endtask

  task automatic read_both(input int port, input logic [4:0] addr);
    for (int k = 0; k < 2; k++) s_raddr[k][port] = addr;
  endtask

  task automatic alloc_both(input logic [4:0] addr);
    for (int k = 0; k < 2; k++) begin
      s_ae[k] = 1'b1;
      s_aaddr[k] = addr;
    end
  endtask

  initial begin
    for (int k = 0; k < 2; k++) m_cnt[k] = 0;
    idle();
    reset = 1'b1;
    @(negedge clock);
    run_cycle();
    check_en = 1'b1;
    reset = 1'b0;

    // Sequential clear: ready low for 32 edges, writes ignored meanwhile.
    for (int c = 0; c < 32; c++) begin
      idle();
      if (c == 10) write_both(0, 5'd5, 32'h0000DEAD);
      check_eq("t1_ready_low", 32'(rdy_a), 32'd0);
      run_cycle();
    end
    check_eq("t1_ready_high", 32'(rdy_a), 32'd1);
    idle();
    read_both(0, 5'd5);
    #1;
    check_eq("t1_x5_a", rd_a[31:0], 32'd0);
    check_eq("t1_x5_b", rd_b[31:0], 32'd0);
    run_cycle();

    // Same-cycle write/read of x3.
    idle();
    write_both(0, 5'd3, 32'h12345678);
    read_both(0, 5'd3);
    #1;
    check_eq("t2_bypass_a", rd_a[31:0], 32'h12345678);
    check_eq("t2_nobypass_b", rd_b[31:0], 32'd0);
    run_cycle();
    idle();
    read_both(0, 5'd3);
    #1;
    check_eq("t2_next_b", rd_b[31:0], 32'h12345678);
    run_cycle();

    // Dual write to x7, write to x0.
    idle();
    write_both(0, 5'd7, 32'h0000000A);
    write_both(1, 5'd7, 32'h0000000B);
    run_cycle();
    idle();
    read_both(0, 5'd7);
    read_both(1, 5'd0);
    write_both(0, 5'd0, 32'hFFFFFFFF);
    #1;
    check_eq("t3_x7_a", rd_a[31:0], 32'h0000000B);
    check_eq("t3_x7_b", rd_b[31:0], 32'h0000000B);
    check_eq("t3_x0_byp_a", rd_a[63:32], 32'd0);
    run_cycle();
    idle();
    read_both(1, 5'd0);
    #1;
    check_eq("t3_x0_a", rd_a[63:32], 32'd0);
    check_eq("t3_x0_b", rd_b[63:32], 32'd0);
    run_cycle();

    // Scoreboard set, clear, and same-edge set priority on x9.
    idle();
    alloc_both(5'd9);
    run_cycle();
    idle();
    read_both(0, 5'd9);
    #1;
    check_eq("t4_pend_set_a", 32'(rp_a[0]), 32'd1);
    check_eq("t4_pend_set_b", 32'(rp_b[0]), 32'd1);
    write_both(0, 5'd9, 32'h00000099);
    run_cycle();
    idle();
    read_both(0, 5'd9);
    #1;
    check_eq("t4_pend_clr_a", 32'(rp_a[0]), 32'd0);
    check_eq("t4_pend_clr_b", 32'(rp_b[0]), 32'd0);
    alloc_both(5'd9);
    write_both(1, 5'd9, 32'h00000999);
    run_cycle();
    idle();
    read_both(0, 5'd9);
    #1;
    check_eq("t4_pend_both_a", 32'(rp_a[0]), 32'd1);
    check_eq("t4_pend_both_b", 32'(rp_b[0]), 32'd1);
    run_cycle();

    // Reset mid-run with x4 pending and holding 0x55.
    idle();
    write_both(0, 5'd4, 32'h00000055);
    run_cycle();
    idle();
    alloc_both(5'd4);
    run_cycle();
    idle();
    read_both(0, 5'd4);
    #1;
    check_eq("t5_pre_data", rd_a[31:0], 32'h00000055);
    check_eq("t5_pre_pend", 32'(rp_a[0]), 32'd1);
    reset = 1'b1;
    run_cycle();
    reset = 1'b0;
    idle();
    read_both(0, 5'd4);
    #1;
    check_eq("t5_ready_low", 32'(rdy_a), 32'd0);
    check_eq("t5_pend_low", 32'(rp_a[0]), 32'd0);
    for (int c = 0; c < 32; c++) begin
      idle();
      read_both(0, 5'd4);
      run_cycle();
    end
    idle();
    read_both(0, 5'd4);
    #1;
    check_eq("t5_ready_high", 32'(rdy_a), 32'd1);
    check_eq("t5_x4_cleared", rd_a[31:0], 32'd0);
    check_eq("t5_x4_pend", 32'(rp_a[0]), 32'd0);
    run_cycle();

    // Four simultaneous reads on the 16-entry instance.
    idle();
    write_both(0, 5'd1, 32'h11111111);
    write_both(1, 5'd2, 32'h22222222);
    run_cycle();
    idle();
    write_both(0, 5'd15, 32'hF15F15F1);
    run_cycle();
    idle();
    s_raddr[1][0] = 5'd1;
    s_raddr[1][1] = 5'd2;
    s_raddr[1][2] = 5'd15;
    s_raddr[1][3] = 5'd0;
    #1;
    check_eq("t6_x1", rd_b[31:0], 32'h11111111);
    check_eq("t6_x2", rd_b[63:32], 32'h22222222);
    check_eq("t6_x15", rd_b[95:64], 32'hF15F15F1);
    check_eq("t6_x0", rd_b[127:96], 32'd0);
    run_cycle();

    // Randomized traffic with occasional resets.
    for (int c = 0; c < 800; c++) begin
      reset = ($urandom_range(0, 299) == 0);
      for (int k = 0; k < 2; k++) begin
        for (int i = 0; i < 4; i++) begin
          s_raddr[k][i] = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 7))
                                                      : 5'($urandom_range(0, depth[k] - 1));
        end
        for (int j = 0; j < NW; j++) begin
          s_we[k][j]    = ($urandom_range(0, 2) == 0);
          s_waddr[k][j] = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 7))
                                                      : 5'($urandom_range(0, depth[k] - 1));
          s_wdata[k][j] = $urandom;
        end
        s_ae[k]    = ($urandom_range(0, 3) == 0);
        s_aaddr[k] = 5'($urandom_range(0, 7));
      end
      run_cycle();
    end
    reset = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
